multi_shift_seq: RTL

Sequencer that performs an N-bit logical shift of a 4-bit word by driving the team's existing combinational 1-bit shifter once per clock. It sits directly upstream of that shifter: it presents the word and the left/right select, captures the shifted result, and repeats until the requested amount is done. Requests arrive and results leave over valid/ready handshakes. The parent instantiates the shifter and wires it to the sh_* ports.

---
 rtl/shift_pkg.sv | 16 +
 rtl/multi_shift_seq.sv | 90 +++++++++
 2 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int WIDTH = 4;
    localparam int AMT_W = 3;

endpackage

// File: rtl/multi_shift_seq.sv
// Drives an external combinational 1-bit shifter once per clock to build an
// N-bit logical shift, with valid/ready request and result handshakes.
module multi_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic [WIDTH-1:0] sh_i,
    output logic             sh_l,
    output logic             sh_r,
    input  logic [WIDTH-1:0] sh_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [AMT_W-1:0]   cnt_q,   cnt_d;
    logic               dir_q,   dir_d;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Outputs depend only on registered state, so there is no input-to-output path.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sh_l      = 1'b0;
        sh_r      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = in_amt;
                    dir_d   = in_dir;
                    state_d = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sh_l   = (dir_q == DIR_LEFT);
                sh_r   = (dir_q == DIR_RIGHT);
                data_d = sh_o;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sh_i     = data_q;
    assign out_data = data_q;
    assign busy     = (state_q != IDLE);

endmodule
